zc_period_meter: RTL and testbench



---
 rtl/zc_meter_pkg.sv | 30 +++
 rtl/zc_avg_filter.sv | 81 ++++++++
 rtl/zc_period_meter.sv | 145 ++++++++++++++
 tb/tb_zc_period_meter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/zc_meter_pkg.sv
// rtl/zc_meter_pkg.sv - shared types, default widths and helpers for the zero-crossing period meter
//
// Contents:
//   zc_state_e      - hysteretic detector state (polarity unknown / low / high)
//   ZC_CNT_W_DEF    - default period counter width
//   ZC_AVG_LOG2_DEF - default log2 averaging depth (PERIOD_AVG_EN builds only)
//   sat_inc()       - saturating increment bounded by an arbitrary bit width (1..32)
package zc_meter_pkg;

    typedef enum logic [1:0] {
        ZC_INIT = 2'd0,
        ZC_LOW  = 2'd1,
        ZC_HIGH = 2'd2
    } zc_state_e;

    localparam int ZC_CNT_W_DEF    = 16;
    localparam int ZC_AVG_LOG2_DEF = 2;

    // Increments cnt but never beyond 2^width-1; callers narrow the result
    // back to their own counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (cnt >= max_v) begin
            return max_v;
        end
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/zc_avg_filter.sv
// rtl/zc_avg_filter.sv - moving average over the last 2^AVG_LOG2 raw period measurements
//
// Ports:
//   clk_i        - sampling clock
//   rst_i        - asynchronous active-high reset; clears ring, sum and fill count
//   meas_valid_i - a new raw measurement is presented this cycle
//   meas_i       - raw period measurement
//   period_o     - registered running sum >> AVG_LOG2 (truncating)
//   valid_o      - one-cycle pulse per measurement once the ring has filled
//   locked_o     - high once the ring has filled
module zc_avg_filter #(
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             meas_valid_i,
    input  logic [CNT_W-1:0] meas_i,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             locked_o
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = CNT_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);

    logic [CNT_W-1:0]    ring_q [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr_q;
    logic [AVG_LOG2:0]   fill_q;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [CNT_W-1:0]    period_q;
    logic                valid_q;
    logic                locked_q;

    // Unfilled slots hold zero, so the running sum is exact from the first
    // measurement onward: drop the oldest entry, add the newest.
    assign sum_d = sum_q - SUM_W'(ring_q[wr_ptr_q]) + SUM_W'(meas_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (meas_valid_i) begin
                ring_q[wr_ptr_q] <= meas_i;
                wr_ptr_q         <= wr_ptr_q + AVG_LOG2'(1);
                sum_q            <= sum_d;
                if (fill_q != FILL_FULL) begin
                    fill_q <= fill_q + (AVG_LOG2 + 1)'(1);
                end
                // This measurement completes (or extends) a full window.
                if (fill_q >= FILL_LAST) begin
                    period_o_load(sum_d);
                end
            end
        end
    end

    // Kept as a tiny helper so the averaging output update reads as one step.
    task automatic period_o_load(input logic [SUM_W-1:0] s);
        period_q <= CNT_W'(s >> AVG_LOG2);
        valid_q  <= 1'b1;
        locked_q <= 1'b1;
    endtask

    assign period_o = period_q;
    assign valid_o  = valid_q;
    assign locked_o = locked_q;

endmodule

// File: rtl/zc_period_meter.sv
// rtl/zc_period_meter.sv - hysteretic zero-crossing detector measuring samples between rising crossings
//
// Optional build macro: PERIOD_AVG_EN (report a 2^AVG_LOG2-deep moving average
// instead of the raw measurement; valid/locked wait for the window to fill).
//
// Ports:
//   clk    - sampling clock (period may vary); all state updates on its rising edge
//   rst    - asynchronous active-high reset
//   in     - sampled real waveform, stable between clk edges
//   period - samples between the last two rising crossings (saturating)
//   valid  - one-cycle pulse when period updates
//   locked - high once a full period has been measured
//   ovf    - sticky, set when the period counter saturates
module zc_period_meter
    import zc_meter_pkg::*;
#(
    parameter real THRESH_HI = 0.1,
    parameter real THRESH_LO = -0.1,
    parameter int  CNT_W     = ZC_CNT_W_DEF,
    parameter int  AVG_LOG2  = ZC_AVG_LOG2_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  real              in,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             ovf
);

    if (THRESH_LO >= THRESH_HI) begin : g_bad_thresh
        $error("zc_period_meter: THRESH_LO must be below THRESH_HI");
    end
    if (AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_bad_avg
        $error("zc_period_meter: AVG_LOG2 must be in 1..8");
    end
    if (CNT_W < 2 || CNT_W > 31) begin : g_bad_cnt
        $error("zc_period_meter: CNT_W must be in 2..31");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    zc_state_e        state_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             hi_hit;
    logic             lo_hit;
    logic             rise;
    logic             meas_fire;

    assign hi_hit = (in >= THRESH_HI);
    assign lo_hit = (in <= THRESH_LO);

    // Only a LOW->HIGH transition counts; leaving INIT upward has no known
    // prior polarity and is not a crossing.
    assign rise      = (state_q == ZC_LOW) && hi_hit;
    assign meas_fire = rise && armed_q;
    assign cnt_d     = CNT_W'(sat_inc(32'(cnt_q), CNT_W));

`ifndef PERIOD_AVG_EN
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             locked_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ZC_INIT;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
`ifndef PERIOD_AVG_EN
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ZC_INIT: begin
                    if (hi_hit) begin
                        state_q <= ZC_HIGH;
                    end else if (lo_hit) begin
                        state_q <= ZC_LOW;
                    end
                end
                ZC_LOW: begin
                    if (hi_hit) begin
                        state_q <= ZC_HIGH;
                    end
                end
                ZC_HIGH: begin
                    if (lo_hit) begin
                        state_q <= ZC_LOW;
                    end
                end
                default: state_q <= ZC_INIT;
            endcase

            // cnt holds the number of edges since the last crossing, counting
            // the crossing edge itself, so at the next crossing it equals N.
            if (rise) begin
                armed_q <= 1'b1;
                cnt_q   <= CNT_ONE;
            end else if (armed_q) begin
                cnt_q <= cnt_d;
                if (cnt_d == CNT_MAX) begin
                    ovf_q <= 1'b1;
                end
            end

`ifndef PERIOD_AVG_EN
            valid_q <= meas_fire;
            if (meas_fire) begin
                period_q <= cnt_q;
                locked_q <= 1'b1;
            end
`endif
        end
    end

`ifdef PERIOD_AVG_EN
    zc_avg_filter #(
        .CNT_W    (CNT_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk_i        (clk),
        .rst_i        (rst),
        .meas_valid_i (meas_fire),
        .meas_i       (cnt_q),
        .period_o     (period),
        .valid_o      (valid),
        .locked_o     (locked)
    );
`else
    assign period = period_q;
    assign valid  = valid_q;
    assign locked = locked_q;
`endif

    assign ovf = ovf_q;

endmodule

// File: tb/tb_zc_period_meter.sv
// tb/tb_zc_period_meter.sv - directed self-checking bench for zc_period_meter
module tb_zc_period_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    real         in_a = 0.0;
    real         in_b = 0.0;
    logic [15:0] period_a;
    logic        valid_a;
    logic        locked_a;
    logic        ovf_a;
    logic [3:0]  period_b;
    logic        valid_b;
    logic        locked_b;
    logic        ovf_b;
    int          errors = 0;
    int          checks = 0;
    int          nval;

    always #5 clk = ~clk;

    zc_period_meter u_dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_a),
        .period (period_a),
        .valid  (valid_a),
        .locked (locked_a),
        .ovf    (ovf_a)
    );

    zc_period_meter #(.CNT_W(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .in     (in_b),
        .period (period_b),
        .valid  (valid_b),
        .locked (locked_b),
        .ovf    (ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input real va, input real vb);
        @(negedge clk);
        in_a = va;
        in_b = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        in_a = 0.0;
        in_b = 0.0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic real sine(input int n, input int num, input int den);
        return $sin(2.0 * 3.14159265358979 * real'(n * num) / real'(den));
    endfunction

    initial begin
        do_reset();
        chk("rst_period", 32'(period_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_locked", 32'(locked_a), 0);
        chk("rst_ovf", 32'(ovf_a), 0);

`ifdef PERIOD_AVG_EN
        // Raw periods 20, 20, 21, 23 -> average 84/4 = 21 on the 4th only.
        begin
            int periods [4] = '{20, 20, 21, 23};
            step(-0.5, 0.0);
            step(0.5, 0.0);
            for (int k = 0; k < 4; k++) begin
                for (int j = 1; j < periods[k]; j++) begin
                    step(-0.5, 0.0);
                    chk("t6_quiet", 32'(valid_a), 0);
                end
                step(0.5, 0.0);
                if (k < 3) begin
                    chk("t6_no_valid", 32'(valid_a), 0);
                    chk("t6_not_locked", 32'(locked_a), 0);
                end else begin
                    chk("t6_valid", 32'(valid_a), 1);
                    chk("t6_period", 32'(period_a), 21);
                    chk("t6_locked", 32'(locked_a), 1);
                end
            end
        end
`else
        // 20 samples per cycle: high at n=1, low at n=11, rising at 21,41,61,81.
        nval = 0;
        for (int n = 0; n <= 90; n++) begin
            step(sine(n, 1, 20), 0.0);
            if (n == 21) chk("t1_first_evt_no_valid", 32'(valid_a), 0);
            if (n == 40) chk("t1_unlocked_before", 32'(locked_a), 0);
            if (n == 41 || n == 61 || n == 81) begin
                chk("t1_valid", 32'(valid_a), 1);
                chk("t1_period", 32'(period_a), 20);
            end
            if (n == 42) chk("t1_valid_drop", 32'(valid_a), 0);
            if (valid_a) nval++;
        end
        chk("t1_valid_count", 32'(nval), 3);
        chk("t1_locked", 32'(locked_a), 1);

        // Aliased: 0, -0.87, +0.87 repeating; rising at n=2,5,8,...
        do_reset();
        for (int n = 0; n <= 20; n++) begin
            logic exp_v;
            step(sine(n, 2, 3), 0.0);
            exp_v = (n >= 5) && (n % 3 == 2);
            chk("t2_valid", 32'(valid_a), 32'(exp_v));
            if (exp_v) chk("t2_period", 32'(period_a), 3);
        end

        // Inside the hysteresis band: never leaves INIT.
        do_reset();
        nval = 0;
        for (int n = 0; n < 20; n++) begin
            step((n % 2 == 0) ? 0.05 : -0.05, 0.0);
            if (valid_a) nval++;
        end
        chk("t3_valid_count", 32'(nval), 0);
        chk("t3_period", 32'(period_a), 0);
        chk("t3_locked", 32'(locked_a), 0);

        // 4-bit counter: arm, hold high, saturate at 15.
        do_reset();
        step(0.0, -0.5);
        step(0.0, 0.5);
        chk("t4_arm_no_valid", 32'(valid_b), 0);
        for (int i = 1; i <= 30; i++) begin
            step(0.0, 0.5);
            if (i == 13) chk("t4_ovf_before", 32'(ovf_b), 0);
            if (i == 14) chk("t4_ovf_set", 32'(ovf_b), 1);
        end
        step(0.0, -0.5);
        chk("t4_low_no_valid", 32'(valid_b), 0);
        step(0.0, 0.5);
        chk("t4_valid", 32'(valid_b), 1);
        chk("t4_period", 32'(period_b), 15);
        chk("t4_locked", 32'(locked_b), 1);
        step(0.0, 0.5);
        chk("t4_valid_drop", 32'(valid_b), 0);
        chk("t4_ovf_sticky", 32'(ovf_b), 1);
        chk("t4_main_ovf", 32'(ovf_a), 0);

        // Mid-period asynchronous reset.
        do_reset();
        for (int n = 0; n <= 50; n++) begin
            step(sine(n, 1, 20), 0.0);
        end
        chk("t5_pre_period", 32'(period_a), 20);
        chk("t5_pre_locked", 32'(locked_a), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_period", 32'(period_a), 0);
        chk("t5_rst_valid", 32'(valid_a), 0);
        chk("t5_rst_locked", 32'(locked_a), 0);
        chk("t5_rst_ovf", 32'(ovf_a), 0);
        rst = 1'b0;
        nval = 0;
        for (int n = 51; n <= 81; n++) begin
            step(sine(n, 1, 20), 0.0);
            if (n < 81 && valid_a) nval++;
            if (n == 61) chk("t5_rearm_unlocked", 32'(locked_a), 0);
            if (n == 81) begin
                chk("t5_valid", 32'(valid_a), 1);
                chk("t5_period", 32'(period_a), 20);
            end
        end
        chk("t5_no_early_valid", 32'(nval), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
